// File: rtl/bus_master_8085_if.sv
// Core-side request/response and 8085 bus control signals.
// AD stays a plain inout on the master because it is tri-stated.
interface bus_master_8085_if;
  logic        req;
  logic        req_we;
  logic        req_io;
  logic [15:0] req_addr;
  logic [7:0]  req_wdata;
  logic        busy;
  logic        done;
  logic [7:0]  rdata;
  logic        err;
  logic [7:0]  A;
  logic        ALE;
  logic        RDn;
  logic        WRn;
  logic        IO_Mn;
  logic        READY;

  modport master (
    input  req, req_we, req_io, req_addr, req_wdata, READY,
    output busy, done, rdata, err, A, ALE, RDn, WRn, IO_Mn
  );

  modport slave (
    output req, req_we, req_io, req_addr, req_wdata, READY,
    input  busy, done, rdata, err, A, ALE, RDn, WRn, IO_Mn
  );
endinterface

// File: rtl/bus_master_8085.sv
// 8085-style bus cycle initiator: T1/T2/[Tw]/T3 machine cycles
// on a multiplexed AD bus, with READY waits and a timeout.
module bus_master_8085 #(
  parameter int unsigned TIMEOUT = 15
) (
  input  logic                CLK,
  input  logic                RESET,
  bus_master_8085_if.master   bus,
  inout  wire  [7:0]          AD
);

  localparam logic [7:0] TMO = 8'(TIMEOUT);

  typedef enum logic [2:0] {
    S_IDLE,
    S_T1,
    S_T2,
    S_TW,
    S_T3
  } state_e;

  state_e      state_q, state_d;
  logic [7:0]  cnt_q, cnt_d;
  logic        err_q, err_d;
  logic        we_q, we_d;
  logic        io_q, io_d;
  logic [15:0] addr_q, addr_d;
  logic [7:0]  wdata_q, wdata_d;
  logic        busy_q, busy_d;
  logic        done_q, done_d;
  logic [7:0]  rdata_q, rdata_d;
  logic [7:0]  a_q, a_d;
  logic        ale_q, ale_d;
  logic        rdn_q, rdn_d;
  logic        wrn_q, wrn_d;
  logic        iom_q, iom_d;
  logic        oe_q, oe_d;
  logic [7:0]  ad_q, ad_d;
  logic        accept;
  logic        data_ph;

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    err_d   = err_q;
    accept  = 1'b0;
    unique case (state_q)
      S_IDLE: begin
        if (bus.req) begin
          state_d = S_T1;
          accept  = 1'b1;
        end
      end
      S_T1: state_d = S_T2;
      S_T2: begin
        if (bus.READY) begin
          state_d = S_T3;
        end else begin
          state_d = S_TW;
          cnt_d   = '0;
        end
      end
      S_TW: begin
        cnt_d = cnt_q + 8'd1;
        if (bus.READY) begin
          state_d = S_T3;
        end else if (TIMEOUT != 0 && cnt_d == TMO) begin
          state_d = S_T3;
          err_d   = 1'b1;
        end
      end
      S_T3: state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
    if (accept) err_d = 1'b0;
  end

  // Bus outputs are derived from the next state so they are registered.
  always_comb begin
    we_d    = accept ? bus.req_we    : we_q;
    io_d    = accept ? bus.req_io    : io_q;
    addr_d  = accept ? bus.req_addr  : addr_q;
    wdata_d = accept ? bus.req_wdata : wdata_q;
    data_ph = (state_d == S_T2) || (state_d == S_TW)
           || (state_d == S_T3);
    ale_d   = (state_d == S_T1);
    rdn_d   = !(data_ph && !we_d);
    wrn_d   = !(data_ph && we_d);
    oe_d    = ale_d || (data_ph && we_d);
    ad_d    = ale_d ? addr_d[7:0] : wdata_d;
    a_d     = ale_d ? addr_d[15:8] : a_q;
    iom_d   = ale_d ? io_d : iom_q;
    busy_d  = (state_d != S_IDLE);
    done_d  = (state_q == S_T3);
    rdata_d = (state_q == S_T3 && !we_q) ? AD : rdata_q;
  end

  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      err_q   <= 1'b0;
      we_q    <= 1'b0;
      io_q    <= 1'b0;
      addr_q  <= '0;
      wdata_q <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      rdata_q <= '0;
      a_q     <= '0;
      ale_q   <= 1'b0;
      rdn_q   <= 1'b1;
      wrn_q   <= 1'b1;
      iom_q   <= 1'b0;
      oe_q    <= 1'b0;
      ad_q    <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      err_q   <= err_d;
      we_q    <= we_d;
      io_q    <= io_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
      rdata_q <= rdata_d;
      a_q     <= a_d;
      ale_q   <= ale_d;
      rdn_q   <= rdn_d;
      wrn_q   <= wrn_d;
      iom_q   <= iom_d;
      oe_q    <= oe_d;
      ad_q    <= ad_d;
    end
  end

  assign AD        = oe_q ? ad_q : 8'bz;
  assign bus.busy  = busy_q;
  assign bus.done  = done_q;
  assign bus.rdata = rdata_q;
  assign bus.err   = err_q;
  assign bus.A     = a_q;
  assign bus.ALE   = ale_q;
  assign bus.RDn   = rdn_q;
  assign bus.WRn   = wrn_q;
  assign bus.IO_Mn = iom_q;

endmodule
